dram_responder: RTL and testbench

- Target side of the DRAM request/busy handshake that the bus arbiter drives; it stands in for the DRAM controller.
- Accepts one-cycle load (le) or store (we_t) triggers, raises busy for a fixed latency, then returns load data.
- Backed by an internal word-organised synchronous RAM with byte-lane writes.
- After reset it zero-clears the RAM, then raises init_done.

---
 rtl/dram_responder_if.sv | 23 ++
 rtl/dram_responder.sv | 200 ++++++++++++++++++++
 tb/tb_dram_responder.sv | 158 +++++++++++++++
 3 files changed

// File: rtl/dram_responder_if.sv
// DRAM request/busy handshake between the bus arbiter (master) and the responder (slave).
// Triggers are one-cycle levels sampled only while busy is low; data returns when busy falls.
interface dram_responder_if;
  logic [31:0] w_dram_addr;
  logic [31:0] w_dram_wdata;
  logic [2:0]  w_dram_ctrl;
  logic        w_dram_le;
  logic        w_dram_we_t;
  logic [31:0] w_dram_odata;
  logic        w_dram_busy;
  logic        w_init_done;
  logic        w_dram_err;

  modport master (
    output w_dram_addr, w_dram_wdata, w_dram_ctrl, w_dram_le, w_dram_we_t,
    input  w_dram_odata, w_dram_busy, w_init_done, w_dram_err
  );

  modport slave (
    input  w_dram_addr, w_dram_wdata, w_dram_ctrl, w_dram_le, w_dram_we_t,
    output w_dram_odata, w_dram_busy, w_init_done, w_dram_err
  );
endinterface

// File: rtl/dram_responder.sv
// DRAM controller stand-in: zero-clears its RAM after reset, then serves one load/store at a time.
// Each access holds busy high for LATENCY cycles; triggers are ignored whenever busy is high.
module dram_responder #(
  parameter int DEPTH   = 1024,
  parameter int LATENCY = 4
) (
  input  logic             CLK,
  input  logic             RST_X,
  dram_responder_if.slave  bus
);
  localparam int AW = $clog2(DEPTH);

  typedef enum logic [1:0] {
    S_CLEAR = 2'd0,
    S_IDLE  = 2'd1,
    S_WAIT  = 2'd2
  } state_t;

  state_t      state_q;
  logic [AW-1:0] clr_idx_q;
  logic [7:0]  cnt_q;
  logic        first_q;
  logic        is_store_q;
  logic [1:0]  size_q;
  logic        unsigned_q;
  logic [1:0]  lane_q;
  logic [AW-1:0] widx_q;
  logic [31:0] wdata_q;
  logic        busy_q;
  logic        init_done_q;
  logic        err_q;
  logic [31:0] odata_q;
  logic [31:0] rdata_q;

  logic [31:0] mem [DEPTH];

  // Request decode: size 3 behaves as word; lane is forced to the natural alignment.
  logic [1:0]  size_d;
  logic [1:0]  lane_d;
  logic        misalign_d;
  logic        trig;

  always_comb begin
    size_d     = 2'd2;
    lane_d     = 2'd0;
    misalign_d = 1'b0;
    case (bus.w_dram_ctrl[1:0])
      2'd0: begin
        size_d = 2'd0;
        lane_d = bus.w_dram_addr[1:0];
      end
      2'd1: begin
        size_d     = 2'd1;
        lane_d     = {bus.w_dram_addr[1], 1'b0};
        misalign_d = bus.w_dram_addr[0];
      end
      default: begin
        size_d     = 2'd2;
        lane_d     = 2'd0;
        misalign_d = (bus.w_dram_addr[1:0] != 2'd0);
      end
    endcase
  end

  assign trig = bus.w_dram_le | bus.w_dram_we_t;

  // Store lane enables and replicated write data for the latched request.
  logic [3:0]  st_be;
  logic [31:0] st_wd;

  always_comb begin
    st_be = 4'b1111;
    st_wd = wdata_q;
    case (size_q)
      2'd0: begin
        st_be = 4'b0001 << lane_q;
        st_wd = {4{wdata_q[7:0]}};
      end
      2'd1: begin
        st_be = 4'b0011 << lane_q;
        st_wd = {2{wdata_q[15:0]}};
      end
      default: begin
        st_be = 4'b1111;
        st_wd = wdata_q;
      end
    endcase
  end

  // Single RAM port shared between the post-reset clear and store writes.
  logic          ram_we;
  logic          ram_re;
  logic [AW-1:0] ram_addr;
  logic [3:0]    ram_be;
  logic [31:0]   ram_wd;

  always_comb begin
    ram_we   = 1'b0;
    ram_re   = 1'b0;
    ram_addr = widx_q;
    ram_be   = st_be;
    ram_wd   = st_wd;
    if (RST_X) begin
      if (state_q == S_CLEAR) begin
        ram_we   = 1'b1;
        ram_addr = clr_idx_q;
        ram_be   = 4'b1111;
        ram_wd   = 32'd0;
      end else if (state_q == S_WAIT && first_q) begin
        ram_we = is_store_q;
        ram_re = ~is_store_q;
      end
    end
  end

  always_ff @(posedge CLK) begin
    if (ram_we) begin
      for (int i = 0; i < 4; i++) begin
        if (ram_be[i]) mem[ram_addr][8*i +: 8] <= ram_wd[8*i +: 8];
      end
    end
    if (ram_re) rdata_q <= mem[widx_q];
  end

  // Load extraction: shift the addressed lane down, then sign- or zero-extend.
  logic [31:0] shifted;
  logic [31:0] ld_val;

  always_comb begin
    shifted = rdata_q >> {lane_q, 3'b000};
    ld_val  = shifted;
    case (size_q)
      2'd0:    ld_val = {{24{shifted[7]  & ~unsigned_q}}, shifted[7:0]};
      2'd1:    ld_val = {{16{shifted[15] & ~unsigned_q}}, shifted[15:0]};
      default: ld_val = shifted;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (!RST_X) begin
      state_q     <= S_CLEAR;
      clr_idx_q   <= '0;
      cnt_q       <= 8'd0;
      first_q     <= 1'b0;
      is_store_q  <= 1'b0;
      size_q      <= 2'd0;
      unsigned_q  <= 1'b0;
      lane_q      <= 2'd0;
      widx_q      <= '0;
      wdata_q     <= 32'd0;
      busy_q      <= 1'b1;
      init_done_q <= 1'b0;
      err_q       <= 1'b0;
      odata_q     <= 32'd0;
    end else begin
      err_q <= 1'b0;
      case (state_q)
        S_CLEAR: begin
          clr_idx_q <= clr_idx_q + 1'b1;
          if (clr_idx_q == AW'(DEPTH - 1)) begin
            state_q     <= S_IDLE;
            busy_q      <= 1'b0;
            init_done_q <= 1'b1;
          end
        end
        S_IDLE: begin
          if (trig) begin
            is_store_q <= ~bus.w_dram_le;
            size_q     <= size_d;
            unsigned_q <= bus.w_dram_ctrl[2];
            lane_q     <= lane_d;
            widx_q     <= bus.w_dram_addr[AW+1:2];
            wdata_q    <= bus.w_dram_wdata;
            err_q      <= (bus.w_dram_le & bus.w_dram_we_t) | misalign_d;
            cnt_q      <= 8'(LATENCY - 1);
            first_q    <= 1'b1;
            busy_q     <= 1'b1;
            state_q    <= S_WAIT;
          end
        end
        S_WAIT: begin
          first_q <= 1'b0;
          if (cnt_q == 8'd0) begin
            state_q <= S_IDLE;
            busy_q  <= 1'b0;
            if (!is_store_q) odata_q <= ld_val;
          end else begin
            cnt_q <= cnt_q - 8'd1;
          end
        end
        default: state_q <= S_CLEAR;
      endcase
    end
  end

  assign bus.w_dram_odata = odata_q;
  assign bus.w_dram_busy  = busy_q;
  assign bus.w_init_done  = init_done_q;
  assign bus.w_dram_err   = err_q;
endmodule

// File: tb/tb_dram_responder.sv
// Directed bench for dram_responder with DEPTH=16, LATENCY=4; expected values are hand-computed.
module tb_dram_responder;
  localparam int DEPTH   = 16;
  localparam int LATENCY = 4;

  logic CLK = 1'b0;
  logic RST_X;
  int   checks = 0;
  int   errors = 0;

  dram_responder_if bus();

  dram_responder #(.DEPTH(DEPTH), .LATENCY(LATENCY)) dut (
    .CLK   (CLK),
    .RST_X (RST_X),
    .bus   (bus)
  );

  always #5 CLK = ~CLK;

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Count cycles busy stays high from now (budget-bounded).
  task automatic count_busy(output int n);
    n = 0;
    while (bus.w_dram_busy === 1'b1 && n < 100) begin
      n++;
      tick();
    end
  endtask

  // One access: trigger for one cycle, measure busy span and the err pulse.
  task automatic access(input logic le, input logic we, input logic [31:0] addr,
                        input logic [31:0] wdata, input logic [2:0] ctrl,
                        output int n, output logic e1, output logic e2);
    bus.w_dram_addr  = addr;
    bus.w_dram_wdata = wdata;
    bus.w_dram_ctrl  = ctrl;
    bus.w_dram_le    = le;
    bus.w_dram_we_t  = we;
    tick();
    bus.w_dram_le   = 1'b0;
    bus.w_dram_we_t = 1'b0;
    e1 = bus.w_dram_err;
    e2 = 1'bx;
    n  = 0;
    while (bus.w_dram_busy === 1'b1 && n < 100) begin
      n++;
      tick();
      if (n == 1) e2 = bus.w_dram_err;
    end
  endtask

  initial begin
    int   n;
    logic e1, e2;

    RST_X            = 1'b0;
    bus.w_dram_addr  = 32'd0;
    bus.w_dram_wdata = 32'd0;
    bus.w_dram_ctrl  = 3'd0;
    bus.w_dram_le    = 1'b0;
    bus.w_dram_we_t  = 1'b0;
    repeat (3) tick();

    check("rst_busy", 32'(bus.w_dram_busy), 32'd1);
    check("rst_init", 32'(bus.w_init_done), 32'd0);
    check("rst_odata", bus.w_dram_odata, 32'd0);
    check("rst_err", 32'(bus.w_dram_err), 32'd0);

    RST_X = 1'b1;
    count_busy(n);
    check("clear_cycles", n, DEPTH);
    check("clear_init", 32'(bus.w_init_done), 32'd1);

    access(1'b1, 1'b0, 32'h3C, 32'd0, 3'd2, n, e1, e2);
    check("lw3c_lat", n, LATENCY);
    check("lw3c_data", bus.w_dram_odata, 32'h0);
    check("lw3c_err", 32'(e1), 32'd0);

    access(1'b0, 1'b1, 32'h10, 32'h804020FF, 3'd2, n, e1, e2);
    check("sw_lat", n, LATENCY);
    access(1'b1, 1'b0, 32'h10, 32'd0, 3'd2, n, e1, e2);
    check("lw_lat", n, LATENCY);
    check("lw_data", bus.w_dram_odata, 32'h804020FF);

    access(1'b1, 1'b0, 32'h13, 32'd0, 3'd0, n, e1, e2);
    check("lb13", bus.w_dram_odata, 32'hFFFFFF80);
    access(1'b1, 1'b0, 32'h13, 32'd0, 3'd4, n, e1, e2);
    check("lbu13", bus.w_dram_odata, 32'h00000080);
    access(1'b1, 1'b0, 32'h12, 32'd0, 3'd1, n, e1, e2);
    check("lh12", bus.w_dram_odata, 32'hFFFF8040);
    access(1'b1, 1'b0, 32'h10, 32'd0, 3'd5, n, e1, e2);
    check("lhu10", bus.w_dram_odata, 32'h000020FF);

    // Misaligned half: aligned down to 0x10, err pulses once.
    access(1'b1, 1'b0, 32'h11, 32'd0, 3'd1, n, e1, e2);
    check("mis_err", 32'(e1), 32'd1);
    check("mis_err_pulse", 32'(e2), 32'd0);
    check("mis_data", bus.w_dram_odata, 32'h000020FF);
    check("mis_lat", n, LATENCY);

    access(1'b0, 1'b1, 32'h11, 32'h000000AA, 3'd0, n, e1, e2);
    access(1'b1, 1'b0, 32'h10, 32'd0, 3'd2, n, e1, e2);
    check("sb_lw", bus.w_dram_odata, 32'h8040AAFF);
    access(1'b0, 1'b1, 32'h12, 32'h00001234, 3'd1, n, e1, e2);
    check("sh_odata_hold", bus.w_dram_odata, 32'h8040AAFF);
    check("sh_err", 32'(e1), 32'd0);
    access(1'b1, 1'b0, 32'h10, 32'd0, 3'd2, n, e1, e2);
    check("sh_lw", bus.w_dram_odata, 32'h1234AAFF);

    // Both triggers: load wins, err flags it, nothing is written.
    access(1'b1, 1'b0, 32'h3C, 32'd0, 3'd2, n, e1, e2);
    check("pre_both", bus.w_dram_odata, 32'h0);
    access(1'b1, 1'b1, 32'h10, 32'hDEADBEEF, 3'd2, n, e1, e2);
    check("both_err", 32'(e1), 32'd1);
    check("both_data", bus.w_dram_odata, 32'h1234AAFF);
    access(1'b1, 1'b0, 32'h10, 32'd0, 3'd2, n, e1, e2);
    check("both_nowrite", bus.w_dram_odata, 32'h1234AAFF);

    // Reset in the middle of a store.
    bus.w_dram_addr  = 32'h20;
    bus.w_dram_wdata = 32'hCAFEF00D;
    bus.w_dram_ctrl  = 3'd2;
    bus.w_dram_we_t  = 1'b1;
    tick();
    bus.w_dram_we_t = 1'b0;
    tick();
    RST_X = 1'b0;
    tick();
    check("mid_rst_busy", 32'(bus.w_dram_busy), 32'd1);
    check("mid_rst_init", 32'(bus.w_init_done), 32'd0);
    check("mid_rst_odata", bus.w_dram_odata, 32'd0);
    RST_X = 1'b1;
    count_busy(n);
    check("reclear_cycles", n, DEPTH);
    check("reclear_init", 32'(bus.w_init_done), 32'd1);
    access(1'b1, 1'b0, 32'h20, 32'd0, 3'd2, n, e1, e2);
    check("lost_store", bus.w_dram_odata, 32'h0);
    access(1'b1, 1'b0, 32'h10, 32'd0, 3'd2, n, e1, e2);
    check("cleared_10", bus.w_dram_odata, 32'h0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
